// File: rtl/sync_fifo_pkg.sv
// Shared constants for the single-clock FIFO and its storage array.
package sync_fifo_pkg;

  // Read-mode encoding for the FWFT parameter.
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Default geometry used when the FIFO is instantiated without overrides.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo_dualport_ram_sync.sv
// Simple dual-port storage array: synchronous write port, read port that is
// either registered (one-cycle latency) or asynchronous (for fall-through use).
module dualport_ram_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_REG     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  generate
    if (RD_REG != 0) begin : g_reg_rd
      logic [DATA_WIDTH-1:0] rd_q;

      // Output register: loads only on an accepted read, otherwise holds.
      always_ff @(posedge clk) begin
        if (!rst_n)     rd_q <= '0;
        else if (rd_en) rd_q <= mem[rd_addr];
      end

      assign rd_data = rd_q;
    end else begin : g_async_rd
      // Head entry is presented combinationally; reset and enable are unused.
      logic unused_rd_ctrl;
      assign unused_rd_ctrl = &{1'b0, rst_n, rd_en};
      assign rd_data = mem[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, occupancy, status flag and sticky error logic.
// Storage lives in dualport_ram_sync; FWFT selects registered or fall-through read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter  int FIFO_AFULL  = FIFO_DEPTH - 1,
  parameter  int FIFO_AEMPTY = 1,
  parameter  int FWFT        = FWFT_OFF,
  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] LVL_FULL   = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LVL_AFULL  = PTR_W'(FIFO_AFULL);
  localparam logic [PTR_W-1:0] LVL_AEMPTY = PTR_W'(FIFO_AEMPTY);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      level_nxt;
  logic                  wr_vld;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] ram_q;

  // Pointer MSBs only disambiguate full from empty; level covers that here.
  logic unused_ptr_msb;
  assign unused_ptr_msb = ^{wr_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH]};

  // Requests are gated by the registered flags, so a write while full is
  // dropped even if a read frees a slot on the same edge (and vice versa).
  assign wr_vld    = wr_en & ~full  & ~flush;
  assign rd_vld    = rd_en & ~empty & ~flush;
  assign level_nxt = level + PTR_W'(wr_vld) - PTR_W'(rd_vld);

  // Pointers, occupancy, flags from next level, and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (rd_vld) rd_ptr <= rd_ptr + 1'b1;
      level     <= level_nxt;
      full      <= (level_nxt == LVL_FULL);
      empty     <= (level_nxt == '0);
      afull     <= (level_nxt >= LVL_AFULL);
      aempty    <= (level_nxt <= LVL_AEMPTY);
      overflow  <= overflow  | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  end

  dualport_ram_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_REG     ((FWFT == FWFT_ON) ? 0 : 1)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_vld),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_vld),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (ram_q)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head word falls through; masked to zero while nothing is stored.
      assign rd_data  = empty ? '0 : ram_q;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic rd_valid_q;

      // One-cycle valid pulse alongside the registered read word.
      always_ff @(posedge clk) begin
        if (!rst_n || flush) rd_valid_q <= 1'b0;
        else                 rd_valid_q <= rd_vld;
      end

      assign rd_data  = ram_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-mode and a FWFT instance run in lockstep on
// the same stimulus and are compared against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n, flush, wr_en, rd_en;
  logic [7:0] wr_data;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_overflow, s_underflow;
  logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_overflow, f_underflow;
  logic [4:0] s_level, f_level;
  logic [10:0] s_stat, f_stat;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ov, m_un, m_rv;
  logic [7:0] m_rd;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FIFO_AFULL(15), .FIFO_AEMPTY(1), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty), .afull(s_afull),
    .aempty(s_aempty), .level(s_level), .overflow(s_overflow), .underflow(s_underflow));

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FIFO_AFULL(15), .FIFO_AEMPTY(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty), .afull(f_afull),
    .aempty(f_aempty), .level(f_level), .overflow(f_overflow), .underflow(f_underflow));

  assign s_stat = {s_level, s_full, s_empty, s_afull, s_aempty, s_overflow, s_underflow, s_rd_valid};
  assign f_stat = {f_level, f_full, f_empty, f_afull, f_aempty, f_overflow, f_underflow, f_rd_valid};

  // Expected status vector from queue occupancy: {level, full, empty, afull, aempty, ovf, udf, valid}
  function automatic logic [10:0] exp_stat(input bit fw);
    int n;
    n = q.size();
    return {5'(n), n == 16, n == 0, n >= 15, n <= 1, m_ov, m_un, fw ? (n != 0) : m_rv};
  endfunction

  // Drive one clock of stimulus and advance the model by the FIFO's rules.
  task automatic cycle(input bit w, input bit r, input bit fl, input logic [7:0] d, input bit rb);
    int n;
    rst_n = rb; flush = fl; wr_en = w; rd_en = r; wr_data = d;
    n = q.size();
    if (!rb) begin
      q.delete(); m_ov = 0; m_un = 0; m_rv = 0; m_rd = 8'h00;
    end else if (fl) begin
      q.delete(); m_ov = 0; m_un = 0; m_rv = 0;
    end else begin
      m_rv = 0;
      if (w && n == 16) m_ov = 1;
      if (r && n == 0)  m_un = 1;
      if (r && n > 0) begin m_rd = q.pop_front(); m_rv = 1; end
      if (w && n < 16) q.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) begin
      total++; if (s_stat !== exp_stat(0)) begin bad++; $display("FAIL reset_std_stat got=%h want=%h", s_stat, exp_stat(0)); end
      total++; if (f_stat !== exp_stat(1)) begin bad++; $display("FAIL reset_fwft_stat got=%h want=%h", f_stat, exp_stat(1)); end
      total++; if (s_rd_data !== 8'h00) begin bad++; $display("FAIL reset_std_data got=%h want=00", s_rd_data); end
      total++; if (f_rd_data !== 8'h00) begin bad++; $display("FAIL reset_fwft_data got=%h want=00", f_rd_data); end
      cycle(0, 0, 0, 8'h00, 1);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      cycle(1, 0, 0, 8'(i), 1);
      total++; if (s_stat !== exp_stat(0)) begin bad++; $display("FAIL fill_std_stat i=%0d got=%h want=%h", i, s_stat, exp_stat(0)); end
      total++; if (f_stat !== exp_stat(1)) begin bad++; $display("FAIL fill_fwft_stat i=%0d got=%h want=%h", i, f_stat, exp_stat(1)); end
      total++; if (f_rd_data !== q[0]) begin bad++; $display("FAIL fill_fwft_head i=%0d got=%h want=%h", i, f_rd_data, q[0]); end
    end
    total++; if (s_level !== 5'd16 || s_overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow level=%0d ovf=%b want 16/1", s_level, s_overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 0, 8'h00, 1);
      total++; if (s_stat !== exp_stat(0)) begin bad++; $display("FAIL drain_std_stat i=%0d got=%h want=%h", i, s_stat, exp_stat(0)); end
      total++; if (f_stat !== exp_stat(1)) begin bad++; $display("FAIL drain_fwft_stat i=%0d got=%h want=%h", i, f_stat, exp_stat(1)); end
      total++; if (s_rd_data !== m_rd) begin bad++; $display("FAIL drain_std_data i=%0d got=%h want=%h", i, s_rd_data, m_rd); end
      if (q.size() > 0) begin
        total++; if (f_rd_data !== q[0]) begin bad++; $display("FAIL drain_fwft_head i=%0d got=%h want=%h", i, f_rd_data, q[0]); end
      end
    end
    total++; if (s_rd_data !== 8'h0F || s_underflow !== 1'b1) begin bad++; $display("FAIL drain_underflow data=%h udf=%b want 0f/1", s_rd_data, s_underflow); end
  endtask

  task automatic test_back_to_back();
    cycle(0, 0, 1, 8'h00, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h40 + i), 1);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 0, 8'(8'h80 + i), 1);
      total++; if (s_stat !== exp_stat(0)) begin bad++; $display("FAIL b2b_std_stat i=%0d got=%h want=%h", i, s_stat, exp_stat(0)); end
      total++; if (f_stat !== exp_stat(1)) begin bad++; $display("FAIL b2b_fwft_stat i=%0d got=%h want=%h", i, f_stat, exp_stat(1)); end
      total++; if (s_rd_data !== m_rd) begin bad++; $display("FAIL b2b_std_data i=%0d got=%h want=%h", i, s_rd_data, m_rd); end
      total++; if (f_rd_data !== q[0]) begin bad++; $display("FAIL b2b_fwft_head i=%0d got=%h want=%h", i, f_rd_data, q[0]); end
    end
    total++; if (s_level !== 5'd8 || s_overflow || s_underflow) begin bad++; $display("FAIL b2b_final level=%0d ovf=%b udf=%b want 8/0/0", s_level, s_overflow, s_underflow); end
  endtask

  task automatic test_fwft_single();
    cycle(0, 0, 1, 8'h00, 1);
    cycle(1, 0, 0, 8'hA5, 1);
    cycle(0, 0, 0, 8'h00, 1);
    total++; if (f_empty !== 1'b0 || f_rd_valid !== 1'b1) begin bad++; $display("FAIL fwft_single_flags empty=%b valid=%b want 0/1", f_empty, f_rd_valid); end
    total++; if (f_rd_data !== 8'hA5) begin bad++; $display("FAIL fwft_single_data got=%h want=a5", f_rd_data); end
    cycle(0, 1, 0, 8'h00, 1);
    total++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin bad++; $display("FAIL fwft_pop_flags empty=%b valid=%b want 1/0", f_empty, f_rd_valid); end
    total++; if (s_rd_data !== 8'hA5 || s_rd_valid !== 1'b1) begin bad++; $display("FAIL std_single_data got=%h valid=%b want a5/1", s_rd_data, s_rd_valid); end
  endtask

  task automatic test_flush();
    cycle(0, 0, 1, 8'h00, 1);
    for (int i = 0; i < 17; i++) cycle(1, 0, 0, 8'(8'h10 + i), 1);
    for (int i = 0; i < 6; i++)  cycle(0, 1, 0, 8'h00, 1);
    total++; if (s_level !== 5'd10 || s_overflow !== 1'b1) begin bad++; $display("FAIL flush_pre level=%0d ovf=%b want 10/1", s_level, s_overflow); end
    cycle(1, 0, 1, 8'hEE, 1);
    total++; if (s_stat !== exp_stat(0)) begin bad++; $display("FAIL flush_std_stat got=%h want=%h", s_stat, exp_stat(0)); end
    total++; if (f_stat !== exp_stat(1)) begin bad++; $display("FAIL flush_fwft_stat got=%h want=%h", f_stat, exp_stat(1)); end
    total++; if (s_rd_data !== 8'h15) begin bad++; $display("FAIL flush_std_hold got=%h want=15", s_rd_data); end
    cycle(1, 0, 0, 8'h77, 1);
    total++; if (f_rd_data !== 8'h77 || f_level !== 5'd1) begin bad++; $display("FAIL flush_fwft_head got=%h level=%0d want 77/1", f_rd_data, f_level); end
    cycle(0, 1, 0, 8'h00, 1);
    total++; if (s_rd_data !== 8'h77 || s_rd_valid !== 1'b1) begin bad++; $display("FAIL flush_std_next got=%h valid=%b want 77/1", s_rd_data, s_rd_valid); end
  endtask

  task automatic test_random();
    bit w, r, fl;
    int wp;
    cycle(0, 0, 1, 8'h00, 1);
    for (int i = 0; i < 800; i++) begin
      wp = ((i / 100) % 2 == 1) ? 80 : 25;
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < (105 - wp));
      fl = ($urandom_range(0, 79) == 0);
      cycle(w, r, fl, 8'($urandom), 1);
      total++; if (s_stat !== exp_stat(0)) begin bad++; $display("FAIL rand_std_stat i=%0d got=%h want=%h", i, s_stat, exp_stat(0)); end
      total++; if (f_stat !== exp_stat(1)) begin bad++; $display("FAIL rand_fwft_stat i=%0d got=%h want=%h", i, f_stat, exp_stat(1)); end
      total++; if (s_rd_data !== m_rd) begin bad++; $display("FAIL rand_std_data i=%0d got=%h want=%h", i, s_rd_data, m_rd); end
      if (q.size() > 0) begin
        total++; if (f_rd_data !== q[0]) begin bad++; $display("FAIL rand_fwft_head i=%0d got=%h want=%h", i, f_rd_data, q[0]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    m_ov = 0; m_un = 0; m_rv = 0; m_rd = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_fwft_single();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
